// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and default operand width
package serial_add_ctrl_pkg;
  localparam int DEF_W = 8;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// fa: 1-bit full adder
module fa (
  output logic carry,
  output logic sum,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial W-bit adder, one bit per cycle through a single full adder
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int CW = $clog2(W) + 1;
  logic [1:0]    r_state;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic          r_c, r_cout;
  logic [CW-1:0] r_cnt;
  logic          w_s, w_c;
  fa u_fa (w_c, w_s, r_a[0], r_b[0], r_c);
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  // FSM and datapath: load on accepted start, shift one bit per RUN cycle, final carry on last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_state <= S_RUN;
        r_a     <= a;
        r_b     <= b;
        r_c     <= cin;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_cnt   <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_sum <= {w_s, r_sum[W-1:1]};
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(W - 1)) begin
        r_state <= S_DONE;
        r_cout  <= w_c;
      end
    end else begin
      r_state <= S_IDLE;
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl with W=8
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;
  localparam int W = DEF_W;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  int checks = 0;
  int errors = 0;
  serial_add_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input bit inject, input logic [W-1:0] es, input logic ec);
    int lat, nbusy, both;
    lat = 0; nbusy = 0; both = 0;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; a = 8'h55; b = 8'hAA; cin = ~tc; end
      if (inject && k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (inject && k == 4) start = 1'b0;
      if (busy) nbusy++;
      if (busy && done) both++;
      if (done) begin lat = k; break; end
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, nbusy, 8);
    check({tag, "_busy_done_overlap"}, both, 0);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_sum_held"}, {cout, sum}, {ec, es});
  endtask
  initial begin
    int pulses, last, gap_bad, dcount;
    #2;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("ignore_start", 8'h3C, 8'h11, 1'b0, 1'b1, 8'h4D, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort_no_done", dcount, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    pulses = 0; last = 0; gap_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (last != 0 && k - last != 10) gap_bad++;
        last = k;
        check("held_sum", {cout, sum}, {1'b0, 8'h46});
      end
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_period", gap_bad, 0);
    check("held_first", last, 29);
    for (int k = 0; k < 12; k++) @(negedge clk);
    check("final_idle_busy", busy, 0);
    check("final_sum", {cout, sum}, {1'b0, 8'h46});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
